// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage placed directly after execute. It accepts one
//   instruction per handshake and issues at most one data-memory access for
//   it. While that access is in flight, it stalls the upstream stage. For
//   every completed instruction it produces a single write-back beat.
//   Timeouts and illegal load+store encodings are reported through a sticky
//   error flag. Once the error is raised, the stage stays locked until reset.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   valid_in    execute presents an instruction this cycle
//   mem_read    instruction is a load (LW)
//   mem_write   instruction is a store (SW)
//   alu_result  effective address for LW/SW, ALU result otherwise
//   write_data  store data
//   stall       upstream must hold its inputs this cycle (combinational)
//   mem_en      memory request valid (registered)
//   mem_wr      1 = write, 0 = read (registered)
//   mem_addr    word-aligned request address (registered)
//   mem_wdata   store data to memory (registered)
//   mem_ready   memory completes the access this cycle
//   mem_rdata   load data, valid when mem_ready = 1
//   wb_valid    one-cycle write-back strobe (registered)
//   wb_data     write-back value, held while wb_valid = 0 (registered)
//   err         sticky error flag (registered)
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int MAX_WAIT = 15,  // REQ cycles without mem_ready before timeout
  parameter int WCNT_W   = 8    // wait-counter width, 2**WCNT_W > MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] alu_result,
  input  logic [15:0] write_data,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  // Count value seen on the last REQ cycle that is still allowed to wait.
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              accepting;

  // DONE accepts exactly like IDLE, so back-to-back instructions need no bubble.
  assign accepting = ((state == IDLE) || (state == DONE)) && valid_in;

  // A pass-through never stalls. Any memory op, legal or not, holds upstream
  // from its accept cycle on.
  assign stall = (accepting && (mem_read || mem_write))
               || (state == REQ) || (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. The default
      // below is overridden later in the block, which gives a one-cycle strobe
      // without any extra clear logic.
      wb_valid <= 1'b0;

      unique case (state)
        IDLE, DONE: begin
          if (!valid_in) begin
            state <= IDLE;
          end else if (mem_read && mem_write) begin
            // Illegal encoding: lock up with no memory request.
            state <= ERR;
            err   <= 1'b1;
          end else if (mem_read || mem_write) begin
            state     <= REQ;
            mem_en    <= 1'b1;
            mem_wr    <= mem_write;
            mem_addr  <= {alu_result[15:1], 1'b0};
            mem_wdata <= write_data;
            wait_cnt  <= '0;
          end else begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= alu_result;
          end
        end

        REQ: begin
          // mem_wr, mem_addr and mem_wdata are held because nothing writes
          // them here.
          if (mem_ready) begin
            state    <= DONE;
            mem_en   <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= mem_wr ? 16'h0000 : mem_rdata;
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= ERR;
            mem_en <= 1'b0;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ERR: begin
          // Absorbing until reset.
          state  <= ERR;
          mem_en <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage. Inputs are driven on the falling edge.
//   Registered outputs are compared at the following falling edge.
//   Combinational stall is compared 1 time unit after the inputs change.
//   The bench has three parts:
//     - A table of single-instruction vectors, each applied from reset.
//     - Hand-written multi-cycle sequences: zero-wait load, store with waits,
//       timeout, illegal encoding and reset in mid-access.
//     - A randomized transaction stream. Its expected results come from a
//       per-instruction model: the address is aligned, the write-back value
//       is picked by the op type, and a wait of w cycles gives w+1 request
//       cycles.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read, mem_write;
  logic [15:0] alu_result, write_data;
  logic        stall, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] last_wb;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(MAX_WAIT), .WCNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_result(alu_result),
    .write_data(write_data),
    .stall     (stall),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .err       (err)
  );

  typedef struct {
    logic        valid, rd, wr;
    logic [15:0] alu, wd;
    logic        exp_stall, exp_wbv;
    logic [15:0] exp_wbd;
    logic        exp_men, exp_mwr;
    logic [15:0] exp_maddr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid_in   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_result = '0;
    write_data = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
  endtask

  // Called at a falling edge (or time 0); returns at a falling edge with rst=0.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    last_wb = 16'h0000;
  endtask

  // One instruction, run from IDLE/DONE, that completes after w wait cycles.
  // op: 0 = pass-through, 1 = LW, 2 = SW. Returns at the DONE falling edge.
  task automatic run_txn(input int op, input logic [15:0] alu,
                         input logic [15:0] wd, input logic [15:0] rdata,
                         input int w);
    logic [15:0] exp_addr, exp_wb;
    exp_addr = {alu[15:1], 1'b0};
    exp_wb   = (op == 0) ? alu : (op == 1) ? rdata : 16'h0000;
    valid_in   = 1'b1;
    mem_read   = (op == 1);
    mem_write  = (op == 2);
    alu_result = alu;
    write_data = wd;
    mem_ready  = 1'($urandom_range(0, 1));  // ignored outside REQ
    mem_rdata  = 16'($urandom);
    #1 check("stall_accept", stall, op != 0);
    @(negedge clk);
    if (op != 0) begin
      for (int k = 0; k <= w; k++) begin
        check("req_mem_en", mem_en, 1'b1);
        check("req_mem_wr", mem_wr, op == 2);
        check("req_mem_addr", mem_addr, exp_addr);
        check("req_mem_wdata", mem_wdata, wd);
        check("req_wb_valid", wb_valid, 1'b0);
        check("req_stall", stall, 1'b1);
        mem_ready = (k == w);
        mem_rdata = (k == w) ? rdata : 16'($urandom);
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    check("wb_valid", wb_valid, 1'b1);
    check("wb_data", wb_data, exp_wb);
    check("done_mem_en", mem_en, 1'b0);
    check("done_err", err, 1'b0);
    last_wb = exp_wb;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h5555, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0101, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0100, 16'h2222, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};

    // Reset state.
    do_reset();
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 16'h0000);
    check("rst_err", err, 1'b0);
    @(negedge clk);

    // Single-instruction vectors from reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      valid_in   = vecs[i].valid;
      mem_read   = vecs[i].rd;
      mem_write  = vecs[i].wr;
      alu_result = vecs[i].alu;
      write_data = vecs[i].wd;
      #1 check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      @(negedge clk);
      check($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].exp_wbv);
      check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_wbd);
      check($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].exp_men);
      check($sformatf("vec%0d_mem_wr", i), mem_wr, vecs[i].exp_mwr);
      check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_maddr);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

    // Zero-wait LW, then SW with 3 waits back-to-back, then pass-through.
    do_reset();
    run_txn(1, 16'h0041, 16'h0000, 16'hBEEF, 0);
    run_txn(2, 16'h0100, 16'hA5A5, 16'h7777, 3);
    run_txn(0, 16'h1234, 16'h0000, 16'h0000, 0);
    idle_inputs();
    #1 check("idle_stall", stall, 1'b0);
    @(negedge clk);
    check("idle_wb_valid", wb_valid, 1'b0);
    check("idle_wb_hold", wb_data, 16'h1234);

    // Longest legal wait: ready on the MAX_WAIT-th REQ cycle.
    run_txn(1, 16'h2223, 16'h0000, 16'hC0DE, MAX_WAIT - 1);

    // Timeout: mem_en high for exactly MAX_WAIT cycles, then sticky error.
    do_reset();
    valid_in   = 1'b1;
    mem_read   = 1'b1;
    alu_result = 16'h0300;
    @(negedge clk);
    for (int k = 0; k < MAX_WAIT; k++) begin
      check("to_mem_en", mem_en, 1'b1);
      check("to_err_low", err, 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      valid_in  = 1'b1;
      mem_read  = 1'b0;
      mem_ready = (k == 1);
      #1;
      check("to_mem_en_low", mem_en, 1'b0);
      check("to_err", err, 1'b1);
      check("to_stall", stall, 1'b1);
      check("to_wb_valid", wb_valid, 1'b0);
      @(negedge clk);
    end

    // Illegal encoding: error next cycle and no memory request, ever.
    do_reset();
    valid_in  = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("ill_err", err, 1'b1);
      check("ill_mem_en", mem_en, 1'b0);
      check("ill_wb_valid", wb_valid, 1'b0);
      @(negedge clk);
    end

    // Reset during the 2nd REQ cycle, then a clean pass-through.
    do_reset();
    valid_in   = 1'b1;
    mem_read   = 1'b1;
    alu_result = 16'h0050;
    @(negedge clk);
    @(negedge clk);
    check("mid_mem_en_before", mem_en, 1'b1);
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("mid_mem_en", mem_en, 1'b0);
    check("mid_wb_valid", wb_valid, 1'b0);
    check("mid_err", err, 1'b0);
    check("mid_stall", stall, 1'b0);
    @(negedge clk);
    run_txn(0, 16'h00FF, 16'h0000, 16'h0000, 0);

    // Randomized transaction stream.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int op, w, gap;
      op  = $urandom_range(0, 2);
      w   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MAX_WAIT - 1)
                                         : $urandom_range(0, 4);
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_txn(op, 16'($urandom), 16'($urandom), 16'($urandom), w);
      for (int g = 0; g < gap; g++) begin
        idle_inputs();
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        #1 check("rnd_idle_stall", stall, 1'b0);
        @(negedge clk);
        check("rnd_idle_wb_valid", wb_valid, 1'b0);
        check("rnd_idle_wb_hold", wb_data, last_wb);
        check("rnd_idle_mem_en", mem_en, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
